// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the FSM state encoding, the owner encoding and the latency counter width.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_lat_cnt.sv
// Loadable down-counter with zero flag; times the memory read latency.
// Kept generic so cache or bus-wait logic can reuse it.
module mem_port_lat_cnt
    import mem_port_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
//
// state | meaning
// IDLE  | no access; arbitrate and latch the winner's address/data
// READ  | memory address driven; wait out the read latency, capture data
// WRITE | single-cycle memory write
// ACK   | one-cycle acknowledge to the owner
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_ack_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              owner_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic              grant_ls, grant_if;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a collision the requester that did not win last time goes first.
    always_comb begin
        grant_ls = ls_req_i && (!if_req_i || (last_owner_q == OWNER_IF));
        grant_if = if_req_i && !grant_ls;
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE) begin
            if (grant_ls) begin
                last_owner_d = OWNER_LS;
            end else if (grant_if) begin
                last_owner_d = OWNER_IF;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_owner_q <= OWNER_LS;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        grant_ls = ls_req_i;
        grant_if = if_req_i && !ls_req_i;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    owner_d = OWNER_LS;
                    addr_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    if (ls_we_i) begin
                        state_d = WRITE;
                    end else begin
                        state_d  = READ;
                        cnt_load = 1'b1;
                    end
                end else if (grant_if) begin
                    owner_d  = OWNER_IF;
                    addr_d   = if_addr_i;
                    state_d  = READ;
                    cnt_load = 1'b1;
                end
            end
            READ: begin
                if (cnt_zero) begin
                    if (owner_q == OWNER_LS) begin
                        ls_rdata_d = mem_rdata_i;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                    end
                    state_d = ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WRITE: state_d = ACK;
            ACK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    mem_port_lat_cnt u_lat_cnt (
        .clk_i      (clock_i),
        .rst_ni     (reset_ni),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(RD_LAT - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Every output is a register or a decode of state_q; nothing passes straight from an input.
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wr_o    = (state_q == WRITE);
    assign if_ack_o    = (state_q == ACK) && (owner_q == OWNER_IF);
    assign ls_ack_o    = (state_q == ACK) && (owner_q == OWNER_LS);
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign owner_o     = owner_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle CPU between two requesters: instruction fetch (IF) and load/store (LS).
- Sequences each access through a fixed read-latency wait, then returns data and a one-cycle acknowledge to the owner.
- Sits between the control unit's memory-side signals and the memory instance. The control unit then only raises a request and waits for ack; it no longer steps through hard-coded wait states.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
RD_LAT, 1, memory read latency in cycles (legal 1..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_W  registered fetch data
ls_req  in  1  load/store request; held high until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  data address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_W  registered load data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data
owner  out  1  0 = IF, 1 = LS; valid while busy
busy  out  1  high in any state other than IDLE
state  out  2  current FSM state, for debug visibility

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including rdata registers, latched addr/wdata, owner and the latency counter.
  - mem_wr drops immediately. An in-flight access is abandoned and no ack is issued.
- Output derivation: all outputs are decoded from registered state or come from registers, so none depends combinationally on an input.
- FSM states (2-bit encoding): IDLE=0, READ=1, WRITE=2, ACK=3.
- IDLE:
  - If ls_req=1, grant LS: latch ls_addr, ls_wdata, ls_we; owner<=1.
  - Else if if_req=1, grant IF: latch if_addr; owner<=0.
  - Next state: WRITE when the granted access is a store, otherwise READ with cnt<=RD_LAT-1.
  - With no request, stay in IDLE.
- Arbitration: fixed priority, LS over IF, evaluated only in IDLE. A request arriving mid-transaction waits.
- READ:
  - mem_addr = latched address.
  - If cnt==0: capture mem_rdata into the owner's rdata register, then go to ACK. Otherwise decrement cnt.
- WRITE:
  - Lasts exactly one cycle: mem_wr=1, mem_addr and mem_wdata from latches. Next state ACK.
- ACK:
  - Pulse the owner's ack for one cycle. The other ack stays 0. Next state IDLE.
  - The non-owner's rdata register is never modified.
- Latency, with the request seen in IDLE at cycle 0:
  - Read ack at cycle RD_LAT+1.
  - Write ack at cycle 2.
  - Minimum inter-grant spacing is RD_LAT+2 cycles for reads and 3 cycles for writes.
- Requester rules:
  - Hold req and all payload stable until ack; deassert on the ack edge.
  - If req is still high in the IDLE cycle after ACK, it is treated as a new request.
  - If req drops mid-transaction, the access still completes and ack is still pulsed.
- mem_addr and mem_wdata hold their latched values outside READ/WRITE. No address alignment checking is performed.
- Simultaneous if_req and ls_req in IDLE: LS is granted; IF is granted in the next IDLE if still requesting.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_owner register is updated on each grant; its reset value is 1.
  - When both requests are high in IDLE, the requester that was not last_owner wins.
  - A single requester is always granted.
- Undefined: fixed LS>IF priority as above; no last_owner register exists.

Decomposition:
- Package mem_port_pkg:
  - state enum typedef arb_state_t (IDLE, READ, WRITE, ACK) on logic[1:0].
  - Constants OWNER_IF=1'b0, OWNER_LS=1'b1.
  - Localparam CNT_W=4.
- Sub-module mem_port_lat_cnt:
  - Loadable down-counter with load, value and zero flag.
  - Reused by future cache or bus-wait logic.
- FSM and datapath latches remain in the top module.

Test Plan:
- Reset mid-READ:
  - Stimulus: IF read of 0x0000_0040 with RD_LAT=3; drop reset at cycle 2.
  - Required: mem_wr=0 and state=0 immediately; no if_ack is ever issued; if_rdata=0.
- Single IF read:
  - Stimulus: if_req with if_addr=0x0000_0004, mem_rdata=0x8C01_0000, RD_LAT=1.
  - Required: mem_addr=0x4 from cycle 1; if_ack pulses at cycle 2; if_rdata=0x8C01_0000; ls_ack stays 0.
- Store:
  - Stimulus: ls_req, ls_we=1, ls_addr=0x100, ls_wdata=0xDEAD_BEEF.
  - Required: mem_wr=1 for exactly cycle 1 with those address and data values; ls_ack at cycle 2.
- Collision, fixed priority:
  - Stimulus: if_req and ls_req (load) both high at cycle 0, RD_LAT=2.
  - Required: owner=1; ls_ack at cycle 3; IF granted at cycle 4; if_ack at cycle 7.
- Latency sweep:
  - Stimulus: reads with RD_LAT=1, 4 and 15.
  - Required: ack at cycle RD_LAT+1 in each case; captured data is mem_rdata from the last READ cycle.
- MEM_PORT_ARB_RR_EN defined:
  - Stimulus: both requests held continuously for 4 transactions.
  - Required: grants alternate IF, LS, IF, LS (starting with IF, since last_owner resets to 1). With the macro undefined, all grants go to LS while ls_req stays high.
